spectrum_frame_ctrl: RTL and testbench

Frame-level controller between the FFT magnitude stage (`data_modulus`) and the spectrum display. It aligns to FFT frame boundaries and captures one complete frame of magnitude bins into a ping-pong buffer. It swaps buffers only on display vertical sync, so the display never tears. It serves the display's random-access bin reads and counts delivered, dropped and malformed frames.

---
 rtl/spectrum_bank_ram.sv | 28 ++
 rtl/spectrum_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_spectrum_frame_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_bank_ram.sv
// Simple dual-port bank RAM: write port and a registered read port, contents not reset.
// Read latency 1 cycle; rdata holds when re is low; no backpressure.
module spectrum_bank_ram #(
    parameter int DEPTH = 1024,
    parameter int DW    = 9,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spectrum_frame_ctrl.sv
// Captures whole FFT magnitude frames into a ping-pong RAM, swapping banks only on display vsync.
// Display reads have 1-cycle latency; no backpressure, frames completing while one is pending are dropped.
module spectrum_frame_ctrl #(
    parameter int N_BINS = 512,
    parameter int DW     = 9,
    localparam int AW    = $clog2(N_BINS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] mod_data,
    input  logic          mod_valid,
    input  logic          mod_eop,
    input  logic          disp_vsync,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          frame_ready,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   drop_cnt,
    output logic          err_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        CAPT = 2'd2,
        PEND = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_BIN = AW'(N_BINS - 1);

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic          wbank_q;
    logic          have_frame_q;
    logic          frame_ready_q;
    logic          err_len_q;
    logic [15:0]   frame_cnt_q;
    logic [15:0]   drop_cnt_q;
    logic          rd_hf_q;
    logic [DW-1:0] ram_rdata;
    logic          ram_we;
    logic          eop_vld;

    assign eop_vld = mod_valid & mod_eop;
    assign ram_we  = en & mod_valid & (state_q == CAPT);

    spectrum_bank_ram #(
        .DEPTH (2 * N_BINS),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({wbank_q, wr_ptr_q}),
        .wdata (mod_data),
        .re    (rd_en),
        .raddr ({~wbank_q, rd_addr}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            wbank_q       <= 1'b0;
            have_frame_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            err_len_q     <= 1'b0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
        end else begin
            err_len_q <= 1'b0;
            if (!en) begin
                // Abandon any partial or pending frame; the display bank stays intact.
                state_q       <= IDLE;
                wr_ptr_q      <= '0;
                frame_ready_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= SYNC;
                    SYNC: begin
                        if (eop_vld) begin
                            state_q  <= CAPT;
                            wr_ptr_q <= '0;
                        end
                    end
                    CAPT: begin
                        if (mod_valid) begin
                            if (mod_eop && wr_ptr_q == LAST_BIN) begin
                                state_q       <= PEND;
                                frame_ready_q <= 1'b1;
                                wr_ptr_q      <= '0;
                            end else if (mod_eop) begin
                                // Short frame: the next bin already starts a new frame.
                                err_len_q <= 1'b1;
                                wr_ptr_q  <= '0;
                            end else if (wr_ptr_q == LAST_BIN) begin
                                err_len_q <= 1'b1;
                                wr_ptr_q  <= '0;
                                state_q   <= SYNC;
                            end else begin
                                wr_ptr_q <= wr_ptr_q + 1'b1;
                            end
                        end
                    end
                    PEND: begin
                        if (disp_vsync) begin
                            wbank_q       <= ~wbank_q;
                            have_frame_q  <= 1'b1;
                            frame_cnt_q   <= frame_cnt_q + 16'd1;
                            frame_ready_q <= 1'b0;
                            wr_ptr_q      <= '0;
                            state_q       <= eop_vld ? CAPT : SYNC;
                        end else if (eop_vld) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Blanking flag travels with the read so rd_data holds coherently when rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hf_q <= 1'b0;
        end else if (rd_en) begin
            rd_hf_q <= have_frame_q;
        end
    end

    assign rd_data     = rd_hf_q ? ram_rdata : '0;
    assign frame_ready = frame_ready_q;
    assign frame_cnt   = frame_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign err_len     = err_len_q;

endmodule

// File: tb/tb_spectrum_frame_ctrl.sv
// Directed bench for spectrum_frame_ctrl with N_BINS = 8.
module tb_spectrum_frame_ctrl;

    localparam int NB = 8;
    localparam int DW = 9;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] mod_data;
    logic          mod_valid;
    logic          mod_eop;
    logic          disp_vsync;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          frame_ready;
    logic [15:0]   frame_cnt;
    logic [15:0]   drop_cnt;
    logic          err_len;

    int n_cmp = 0;
    int n_mis = 0;

    spectrum_frame_ctrl #(
        .N_BINS (NB),
        .DW     (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mod_data    (mod_data),
        .mod_valid   (mod_valid),
        .mod_eop     (mod_eop),
        .disp_vsync  (disp_vsync),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt),
        .err_len     (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bin(input logic [DW-1:0] d, input logic eop, input logic vs);
        mod_valid  = 1'b1;
        mod_data   = d;
        mod_eop    = eop;
        disp_vsync = vs;
        tick();
        mod_valid  = 1'b0;
        mod_eop    = 1'b0;
        disp_vsync = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic vsync();
        disp_vsync = 1'b1;
        tick();
        disp_vsync = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        mod_data   = '0;
        mod_valid  = 1'b0;
        mod_eop    = 1'b0;
        disp_vsync = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        #12;
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_frame_ready", 32'(frame_ready), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_err_len", 32'(err_len), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Read before any swap is blanked.
        rd(3'd3);
        chk("pre_swap_read_idle", 32'(rd_data), 0);

        // Stray partial frame aligns, then a good frame 1..8.
        en = 1'b1;
        tick();
        bin(9'd50, 1'b0, 1'b0);
        bin(9'd51, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) bin(9'(i), 1'b0, 1'b0);
        chk("ready_before_last_bin", 32'(frame_ready), 0);
        bin(9'd8, 1'b1, 1'b0);
        chk("ready_after_last_bin", 32'(frame_ready), 1);
        chk("good_frame_no_err", 32'(err_len), 0);
        rd(3'd3);
        chk("pre_swap_read_pend", 32'(rd_data), 0);
        vsync();
        chk("swap1_frame_cnt", 32'(frame_cnt), 1);
        chk("swap1_ready_clear", 32'(frame_ready), 0);
        for (int a = 0; a < NB; a++) begin
            rd(3'(a));
            chk($sformatf("frame1_addr%0d", a), 32'(rd_data), 32'(a + 1));
        end
        tick();
        chk("read_hold", 32'(rd_data), 8);

        // One frame captured, two more dropped while pending.
        bin(9'd0, 1'b1, 1'b0);
        for (int i = 0; i < NB; i++) bin(9'(20 + i), i == NB - 1, 1'b0);
        chk("frameA_ready", 32'(frame_ready), 1);
        for (int i = 0; i < NB; i++) bin(9'(30 + i), i == NB - 1, 1'b0);
        for (int i = 0; i < NB; i++) bin(9'(40 + i), i == NB - 1, 1'b0);
        chk("drop_cnt_two", 32'(drop_cnt), 2);
        chk("ready_held_during_drops", 32'(frame_ready), 1);
        // A read sampled with vsync still sees the old bank.
        disp_vsync = 1'b1;
        rd_en      = 1'b1;
        rd_addr    = 3'd2;
        tick();
        disp_vsync = 1'b0;
        rd_en      = 1'b0;
        chk("read_in_vsync_old_bank", 32'(rd_data), 3);
        chk("swap2_frame_cnt", 32'(frame_cnt), 2);
        rd(3'd2);
        chk("read_after_vsync_new_bank", 32'(rd_data), 22);
        rd(3'd7);
        chk("frameA_addr7", 32'(rd_data), 27);
        rd(3'd0);
        chk("frameA_addr0", 32'(rd_data), 20);

        // Short frame: eop on the 5th bin.
        bin(9'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) bin(9'(10 + i), 1'b0, 1'b0);
        bin(9'd14, 1'b1, 1'b0);
        chk("short_frame_err", 32'(err_len), 1);
        tick();
        chk("short_frame_err_one_cycle", 32'(err_len), 0);
        for (int i = 0; i < NB; i++) bin(9'(60 + i), i == NB - 1, 1'b0);
        chk("restart_after_short_ready", 32'(frame_ready), 1);
        chk("restart_no_drop", 32'(drop_cnt), 2);
        vsync();
        chk("swap3_frame_cnt", 32'(frame_cnt), 3);
        rd(3'd5);
        chk("frame60_addr5", 32'(rd_data), 65);

        // Long frame: 9 bins, eop on the 9th.
        bin(9'd0, 1'b1, 1'b0);
        for (int i = 0; i < NB; i++) bin(9'(70 + i), 1'b0, 1'b0);
        chk("long_frame_err", 32'(err_len), 1);
        bin(9'd78, 1'b1, 1'b0);
        chk("long_frame_err_cleared", 32'(err_len), 0);

        // Realigned frame whose completing eop coincides with vsync.
        for (int i = 0; i < NB - 1; i++) bin(9'(80 + i), 1'b0, 1'b0);
        bin(9'd87, 1'b1, 1'b1);
        chk("eop_vsync_ready", 32'(frame_ready), 1);
        chk("eop_vsync_no_swap", 32'(frame_cnt), 3);
        vsync();
        chk("late_swap_frame_cnt", 32'(frame_cnt), 4);
        rd(3'd1);
        chk("frame80_addr1", 32'(rd_data), 81);

        // Drop enable mid-frame.
        bin(9'd0, 1'b1, 1'b0);
        bin(9'd90, 1'b0, 1'b0);
        bin(9'd91, 1'b0, 1'b0);
        bin(9'd92, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        chk("en_low_state_idle", 32'(dut.state_q), 0);
        chk("en_low_ready", 32'(frame_ready), 0);
        rd(3'd1);
        chk("en_low_keep_addr1", 32'(rd_data), 81);
        rd(3'd7);
        chk("en_low_keep_addr7", 32'(rd_data), 87);
        vsync();
        chk("vsync_in_idle_ignored", 32'(frame_cnt), 4);
        chk("final_drop_cnt", 32'(drop_cnt), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
